// File: rtl/card_pkg.sv
// Shared types and default sizing for the memory-card pair-matching engine.
package card_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    WAIT2,
    FETCH2,
    COMPARE,
    HOLD,
    DONE
  } card_state_e;

  localparam int DEF_NUM_CARDS   = 36;
  localparam int DEF_SYMBOL_W    = 5;
  localparam int DEF_HOLD_CYCLES = 25_000_000;

endpackage

// File: rtl/card_match_engine_hold_timer.sv
// Mismatch reveal timer: loads HOLD_CYCLES, counts down, pulses expire in the last held cycle.
module hold_timer
  import card_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  output logic expire
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means this is the final reveal cycle.
  assign expire = (cnt_q == ONE) && !clear;

endmodule

// File: rtl/card_match_engine.sv
// Pair-matching engine: fetches two picked symbols, compares them, tracks matched cards,
// pair count and game-over, and holds mismatched cards face-up for a programmable time.
module card_match_engine
  import card_pkg::*;
#(
  parameter int NUM_CARDS   = DEF_NUM_CARDS,
  parameter int SYMBOL_W    = DEF_SYMBOL_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int IDX_W = $clog2(NUM_CARDS),
  localparam int PAIRS = NUM_CARDS / 2,
  localparam int CNT_W = $clog2(PAIRS + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 new_game,
  input  logic                 select,
  input  logic [IDX_W-1:0]     sel_index,
  output logic [IDX_W-1:0]     rd_addr,
  input  logic [SYMBOL_W-1:0]  rd_data,
  output logic [SYMBOL_W-1:0]  data1,
  output logic [SYMBOL_W-1:0]  data2,
  output logic [IDX_W-1:0]     idx1,
  output logic [IDX_W-1:0]     idx2,
  output logic                 card_one_two,
  output logic                 reveal,
  output logic [NUM_CARDS-1:0] matched,
  output logic [CNT_W-1:0]     pairs_found,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 reject_pulse,
  output logic                 hide_pulse,
  output logic                 game_over
);

  localparam logic [IDX_W:0]   NUM_L   = (IDX_W + 1)'(NUM_CARDS);
  localparam logic [CNT_W-1:0] PAIRS_L = CNT_W'(PAIRS);
  localparam int               PAD_W   = 1 << IDX_W;

  card_state_e state_q, state_d;
  logic                 phase_q, phase_d;
  logic [IDX_W-1:0]     rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0]     idx1_q, idx1_d;
  logic [IDX_W-1:0]     idx2_q, idx2_d;
  logic [SYMBOL_W-1:0]  data1_q, data1_d;
  logic [SYMBOL_W-1:0]  data2_q, data2_d;
  logic                 c12_q, c12_d;
  logic                 reveal_q, reveal_d;
  logic [NUM_CARDS-1:0] matched_q, matched_d;
  logic [CNT_W-1:0]     pairs_q, pairs_d;

  logic [CNT_W-1:0] pairs_inc;
  logic [PAD_W-1:0] matched_pad;
  logic             accept;
  logic             illegal;
  logic             timer_load;
  logic             timer_expire;
  logic             match_p, mismatch_p, reject_p, hide_p;

  // Padding lets an out-of-range sel_index be looked up safely; the range test rejects it anyway.
  always_comb begin
    matched_pad = '0;
    matched_pad[NUM_CARDS-1:0] = matched_q;
  end

  assign accept  = select & enable & ~new_game;
  assign illegal = ({1'b0, sel_index} >= NUM_L)
                || matched_pad[sel_index]
                || ((state_q == WAIT2) && (sel_index == idx1_q));

  assign pairs_inc = (pairs_q == PAIRS_L) ? pairs_q : pairs_q + CNT_W'(1);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (new_game),
    .load   (timer_load),
    .expire (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rd_addr_d  = rd_addr_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    c12_d      = c12_q;
    reveal_d   = reveal_q;
    matched_d  = matched_q;
    pairs_d    = pairs_q;
    timer_load = 1'b0;
    match_p    = 1'b0;
    mismatch_p = 1'b0;
    reject_p   = 1'b0;
    hide_p     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            reject_p = 1'b1;
          end else begin
            idx1_d    = sel_index;
            rd_addr_d = sel_index;
            phase_d   = 1'b0;
            state_d   = FETCH1;
          end
        end
      end
      // Memory returns data one cycle after rd_addr, so each fetch spans two edges.
      FETCH1: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          data1_d = rd_data;
          c12_d   = 1'b1;
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        if (accept) begin
          if (illegal) begin
            reject_p = 1'b1;
          end else begin
            idx2_d    = sel_index;
            rd_addr_d = sel_index;
            phase_d   = 1'b0;
            state_d   = FETCH2;
          end
        end
      end
      FETCH2: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          data2_d = rd_data;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (data1_q == data2_q) begin
          matched_d[idx1_q] = 1'b1;
          matched_d[idx2_q] = 1'b1;
          pairs_d           = pairs_inc;
          match_p           = 1'b1;
          c12_d             = 1'b0;
          state_d           = (pairs_inc == PAIRS_L) ? DONE : IDLE;
        end else begin
          mismatch_p = 1'b1;
          reveal_d   = 1'b1;
          timer_load = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (timer_expire) begin
          reveal_d = 1'b0;
          c12_d    = 1'b0;
          hide_p   = 1'b1;
          state_d  = IDLE;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // new_game overrides whatever the current state decided this cycle.
    if (new_game) begin
      state_d    = IDLE;
      phase_d    = 1'b0;
      rd_addr_d  = '0;
      idx1_d     = '0;
      idx2_d     = '0;
      data1_d    = '0;
      data2_d    = '0;
      c12_d      = 1'b0;
      reveal_d   = 1'b0;
      matched_d  = '0;
      pairs_d    = '0;
      timer_load = 1'b0;
      match_p    = 1'b0;
      mismatch_p = 1'b0;
      hide_p     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      rd_addr_q <= '0;
      idx1_q    <= '0;
      idx2_q    <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      c12_q     <= 1'b0;
      reveal_q  <= 1'b0;
      matched_q <= '0;
      pairs_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rd_addr_q <= rd_addr_d;
      idx1_q    <= idx1_d;
      idx2_q    <= idx2_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      c12_q     <= c12_d;
      reveal_q  <= reveal_d;
      matched_q <= matched_d;
      pairs_q   <= pairs_d;
    end
  end

  assign rd_addr        = rd_addr_q;
  assign idx1           = idx1_q;
  assign idx2           = idx2_q;
  assign data1          = data1_q;
  assign data2          = data2_q;
  assign card_one_two   = c12_q;
  assign reveal         = reveal_q;
  assign matched        = matched_q;
  assign pairs_found    = pairs_q;
  assign match_pulse    = match_p;
  assign mismatch_pulse = mismatch_p;
  assign reject_pulse   = reject_p;
  assign hide_pulse     = hide_p;
  assign game_over      = (state_q == DONE);

endmodule

// File: tb/tb_card_match_engine.sv
// Bench for card_match_engine: transaction-level pick model checked every cycle, plus pinned literals.
module tb_card_match_engine;

  localparam int N  = 36;
  localparam int SW = 5;
  localparam int HC = 4;
  localparam int IW = 6;
  localparam int CW = 5;
  localparam int NP = N / 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          new_game = 1'b0;
  logic          select = 1'b0;
  logic [IW-1:0] sel_index = '0;
  logic [IW-1:0] rd_addr, idx1, idx2;
  logic [SW-1:0] rd_data = '0;
  logic [SW-1:0] data1, data2;
  logic          card_one_two, reveal;
  logic [N-1:0]  matched;
  logic [CW-1:0] pairs_found;
  logic          match_pulse, mismatch_pulse, reject_pulse, hide_pulse, game_over;

  card_match_engine #(
    .NUM_CARDS(N),
    .SYMBOL_W(SW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .new_game      (new_game),
    .select        (select),
    .sel_index     (sel_index),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .data1         (data1),
    .data2         (data2),
    .idx1          (idx1),
    .idx2          (idx2),
    .card_one_two  (card_one_two),
    .reveal        (reveal),
    .matched       (matched),
    .pairs_found   (pairs_found),
    .match_pulse   (match_pulse),
    .mismatch_pulse(mismatch_pulse),
    .reject_pulse  (reject_pulse),
    .hide_pulse    (hide_pulse),
    .game_over     (game_over)
  );

  always #5 clock = ~clock;

  // Card i and card i+18 share a symbol; pair 0 uses 5'b01111, every pair is distinct.
  function automatic logic [SW-1:0] sym(input int i);
    return SW'(((i % NP) + 15) % 32);
  endfunction

  always @(posedge clock) rd_data <= sym(int'(rd_addr));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle.
  logic [IW-1:0] e_rd, e_idx1, e_idx2;
  logic [SW-1:0] e_d1, e_d2;
  bit            e_c12, e_rev, e_mp, e_mmp, e_rej, e_hide, e_go;
  logic [N-1:0]  e_matched;
  int            e_pairs;
  bit            m_first;
  int            m_idx1;

  task automatic model_clear();
    e_rd = '0; e_idx1 = '0; e_idx2 = '0; e_d1 = '0; e_d2 = '0;
    e_c12 = 0; e_rev = 0; e_mp = 0; e_mmp = 0; e_rej = 0; e_hide = 0; e_go = 0;
    e_matched = '0; e_pairs = 0; m_first = 0; m_idx1 = 0;
  endtask

  always @(negedge clock) begin
    chk("rd_addr", rd_addr, e_rd);
    chk("idx1", idx1, e_idx1);
    chk("idx2", idx2, e_idx2);
    chk("data1", data1, e_d1);
    chk("data2", data2, e_d2);
    chk("card_one_two", card_one_two, e_c12);
    chk("reveal", reveal, e_rev);
    chk("matched", matched, e_matched);
    chk("pairs_found", pairs_found, e_pairs);
    chk("match_pulse", match_pulse, e_mp);
    chk("mismatch_pulse", mismatch_pulse, e_mmp);
    chk("reject_pulse", reject_pulse, e_rej);
    chk("hide_pulse", hide_pulse, e_hide);
    chk("game_over", game_over, e_go);
    chk("pair_invariant", $countones(matched), 2 * pairs_found);
  end

  task automatic tick();
    @(posedge clock);
    #1;
    select = 1'b0;
    new_game = 1'b0;
    e_mp = 0; e_mmp = 0; e_rej = 0; e_hide = 0;
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_reveal", reveal, 0);
    chk("rst_card_one_two", card_one_two, 0);
    chk("rst_matched", matched, 0);
    chk("rst_pairs", pairs_found, 0);
    chk("rst_data1", data1, 0);
    chk("rst_idx2", idx2, 0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One pick; poke injects a select during the reveal hold, rst_k resets in that hold cycle.
  task automatic pick(input int idx, input bit poke, input int rst_k);
    bit legal;
    tick();
    select = 1'b1;
    sel_index = IW'(idx);
    if (e_go) return;
    legal = (idx < N) && !e_matched[idx] && !(m_first && idx == m_idx1);
    if (!legal) begin
      e_rej = 1;
      return;
    end
    tick();
    e_rd = IW'(idx);
    if (!m_first) begin
      e_idx1 = IW'(idx);
      tick();
      tick();
      e_d1 = sym(idx);
      e_c12 = 1;
      m_first = 1;
      m_idx1 = idx;
    end else begin
      e_idx2 = IW'(idx);
      tick();
      tick();
      e_d2 = sym(idx);
      if (sym(idx) == sym(m_idx1)) e_mp = 1;
      else e_mmp = 1;
      tick();
      if (sym(idx) == sym(m_idx1)) begin
        e_matched[idx] = 1'b1;
        e_matched[m_idx1] = 1'b1;
        e_pairs++;
        e_c12 = 0;
        m_first = 0;
        if (e_pairs == NP) e_go = 1;
      end else begin
        e_rev = 1;
        for (int k = 1; k <= HC; k++) begin
          if (k == HC) e_hide = 1;
          if (poke && k == 2) begin
            select = 1'b1;
            sel_index = IW'(3);
          end
          if (rst_k == k) begin
            async_reset();
            return;
          end
          tick();
        end
        e_rev = 0;
        e_c12 = 0;
        m_first = 0;
      end
    end
  endtask

  task automatic new_game_seq();
    tick();
    new_game = 1'b1;
    select = 1'b1;
    sel_index = IW'(7);
    tick();
    model_clear();
  endtask

  initial begin
    model_clear();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // First matching pair.
    pick(0, 0, 0);
    chk("lit_data1_pair0", data1, 5'b01111);
    chk("lit_one_two", card_one_two, 1'b1);
    pick(18, 0, 0);
    tick();
    chk("lit_pairs_1", pairs_found, 1);
    chk("lit_matched_0_18", matched, 36'h000040001);
    chk("lit_data2_pair0", data2, 5'b01111);

    // Illegal picks from IDLE.
    pick(0, 0, 0);
    pick(40, 0, 0);
    tick();
    chk("lit_pairs_after_rej", pairs_found, 1);

    // Same card twice, then its partner.
    pick(5, 0, 0);
    pick(5, 0, 0);
    tick();
    chk("lit_one_two_held", card_one_two, 1'b1);
    pick(23, 0, 0);

    // Mismatch with a select during the hold.
    pick(1, 0, 0);
    pick(2, 1, 0);
    chk("lit_reveal_dropped", reveal, 1'b0);
    chk("lit_pairs_2", pairs_found, 2);

    // Select with enable low is ignored.
    tick();
    enable = 1'b0;
    select = 1'b1;
    sel_index = IW'(3);
    tick();
    enable = 1'b1;

    // Clear the board.
    for (int p = 0; p < NP; p++) begin
      if (!e_matched[p]) begin
        pick(p, 0, 0);
        pick(p + NP, 0, 0);
      end
    end
    tick();
    chk("lit_game_over", game_over, 1'b1);
    chk("lit_pairs_18", pairs_found, 18);
    chk("lit_all_matched", matched, 36'hFFFFFFFFF);
    pick(4, 0, 0);
    tick();
    chk("lit_done_ignores", card_one_two, 1'b0);

    new_game_seq();
    chk("lit_ng_pairs", pairs_found, 0);
    chk("lit_ng_go", game_over, 1'b0);
    new_game_seq();
    tick();
    chk("lit_ng_beats_select", card_one_two, 1'b0);

    // Reset in the middle of a mismatch hold.
    pick(1, 0, 0);
    pick(2, 0, 2);
    tick();
    chk("lit_post_reset_matched", matched, 0);

    // Random soak.
    for (int it = 0; it < 800; it++) begin
      int a, b;
      a = $urandom_range(0, N + 3);
      pick(a, 0, 0);
      if (m_first) begin
        b = ($urandom_range(0, 1) == 1) ? (m_idx1 + NP) % N : $urandom_range(0, N + 3);
        pick(b, ($urandom_range(0, 3) == 0), 0);
      end
      if (e_go) new_game_seq();
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/card_match_engine.md
# card_match_engine

Parametrised pair-matching engine for the memory card game: accepts debounced card-select pulses, fetches each card's symbol from the board symbol memory, compares the two picks, and keeps a per-card matched mask, a pair count and a game-over flag. Mismatched cards stay revealed for a programmable hold time before being hidden. It sits between the input/cursor logic and the VGA renderer and succeeds the fixed 6x6 comparator. It adds configurable board size, symbol width and hold time; rejection of illegal picks; and a synchronous new-game clear.

## Interface
- NUM_CARDS, 36: cards on the board; must be even and at least 2.
- SYMBOL_W, 5: symbol code width.
- HOLD_CYCLES, 25_000_000: mismatch reveal time in clocks; must be at least 1.
- Derived localparams:
  - IDX_W = $clog2(NUM_CARDS).
  - PAIRS = NUM_CARDS/2.
  - CNT_W = $clog2(PAIRS+1).
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  play state active (the FSM's play state); selects are ignored when low.
- new_game  in  1  synchronous clear of mask, count and FSM.
- select  in  1  one-cycle pick pulse.
- sel_index  in  IDX_W  card under cursor, sampled with select.
- rd_addr  out  IDX_W  symbol memory address, registered.
- rd_data  in  SYMBOL_W  symbol memory data, valid one clock after rd_addr changes.
- data1, data2  out  SYMBOL_W  symbols of first and second pick.
- idx1, idx2  out  IDX_W  indices of first and second pick.
- card_one_two  out  1  0 = awaiting first pick, 1 = first pick revealed.
- reveal  out  1  idx1/idx2 currently shown face-up (unmatched).
- matched  out  NUM_CARDS  bit i set when card i is matched.
- pairs_found  out  CNT_W  matched pair count.
- match_pulse, mismatch_pulse, reject_pulse, hide_pulse  out  1  one-cycle events.
- game_over  out  1  all pairs found.

## Operation
- States, held in a single enum: IDLE, FETCH1, WAIT2, FETCH2, COMPARE, HOLD, DONE.
- Selects are only honoured in IDLE and WAIT2.
- Acceptance condition: select, enable and not new_game are all high.
- A select is rejected, with a reject_pulse and no state change, when any of these holds:
  - sel_index >= NUM_CARDS.
  - matched[sel_index] is set.
  - In WAIT2, sel_index == idx1.
- IDLE, on an accepted select:
  - Latch idx1 and set rd_addr = sel_index.
  - Go to FETCH1.
- FETCH1, two cycles long (internal phase bit):
  - On the second edge, capture rd_data into data1.
  - Set card_one_two = 1 and go to WAIT2.
- WAIT2, on an accepted select:
  - Latch idx2 and set rd_addr.
  - Go to FETCH2.
- FETCH2, two cycles long:
  - Capture data2 and go to COMPARE.
- COMPARE, single cycle:
  - Equal symbols: set matched[idx1] and matched[idx2], increment pairs_found, pulse match_pulse, clear card_one_two. Go to DONE if the new count is PAIRS, else IDLE.
  - Unequal symbols: pulse mismatch_pulse, set reveal, load the hold timer, go to HOLD.
- HOLD:
  - Selects are ignored; they are not queued and raise no reject_pulse.
  - When the timer expires: clear reveal and card_one_two, pulse hide_pulse, go to IDLE.
- DONE:
  - game_over = 1.
  - All selects are ignored until new_game or reset.
- enable low: the FSM keeps running through FETCH, COMPARE and HOLD; only select acceptance is blocked.
- new_game, from any state:
  - Next state IDLE; mask, count, data, indices, flags and the timer are all cleared.
  - It wins over a simultaneous select.
- Reset values: all outputs 0, rd_addr 0, matched all-zero, state IDLE.
  - Reset mid-hold or mid-fetch drops the pending picks.
- pairs_found saturates at PAIRS; it is structurally unreachable beyond that.

## Timing
- Accept edge N:
  - rd_addr valid after N.
  - data1 (or data2) valid after edge N+2.
- First pick: card_one_two rises after N+2.
- Second pick accepted at edge M:
  - COMPARE occupies cycle M+3.
  - match_pulse or mismatch_pulse is high during cycle M+3.
  - matched and pairs_found update at edge M+3 and are visible from M+4.
- Mismatch: reveal is high from M+4 for exactly HOLD_CYCLES cycles. hide_pulse is high in the last of those cycles, and reveal drops on the following edge.
- game_over asserts in the same cycle pairs_found reaches PAIRS.
- Minimum spacing: about 3 cycles between picks. Selects arriving during FETCH or COMPARE are ignored.

## Structure
- Package card_pkg holds:
  - The state enum card_state_e.
  - Default constants DEF_NUM_CARDS = 36, DEF_SYMBOL_W = 5, DEF_HOLD_CYCLES.
- Sub-module hold_timer (parameter HOLD_CYCLES):
  - Ports: clock, reset_n, clear, load → expire, a one-cycle pulse.
  - Down-counter of width $clog2(HOLD_CYCLES+1).
- Everything else lives in card_match_engine.

## Test plan
Common bench: NUM_CARDS = 36, SYMBOL_W = 5, HOLD_CYCLES = 4; memory holds symbol 5'b01111 at indices 0 and 18, and all other symbols are unique except their designated partners.

- Pick 0 then 18 → data1 = data2 = 01111, match_pulse at M+3, matched[0] = matched[18] = 1, pairs_found = 1.
- Pick 5 then 5 → second pick raises reject_pulse, state stays WAIT2, card_one_two stays 1, no compare.
- Pick 0 after it is matched, or pick 40 → reject_pulse, state stays IDLE, count unchanged.
- Pick 1 then 2 (different symbols) → mismatch_pulse, reveal high for 4 cycles, then hide_pulse; a select during HOLD is ignored.
- Match all 18 pairs → game_over = 1, pairs_found = 18, further selects ignored; then new_game → all cleared, state IDLE.
- Assert reset_n low during HOLD → all outputs 0 immediately, without waiting for a clock; random 800-pair soak, bench checks that the matched-bit count equals 2·pairs_found throughout.
